// File: rtl/cache_cfg_sequencer.sv
// Collects bit-extraction instructions into a shadow bank and commits them to the
// lookup stage as one word, only while no 4-segment lookup window is open.
module cache_cfg_sequencer #(
  parameter int SEG_ADDR            = 3,
  parameter int CFG_ORDER_NUM       = 128,
  parameter int CFG_SINGE_ORDER_WID = 16,
  parameter int IDX_W               = 7,
  parameter int WIN_TIMEOUT         = 64
) (
  input  logic                                         axis_clk,
  input  logic                                         aresetn,
  input  logic                                         s_cfg_valid,
  output logic                                         s_cfg_ready,
  input  logic [IDX_W-1:0]                             s_cfg_index,
  input  logic [CFG_SINGE_ORDER_WID-1:0]               s_cfg_instr,
  input  logic                                         s_cfg_last,
  input  logic                                         i_cfg_abort,
  input  logic                                         i_dp_segs_valid,
  input  logic [SEG_ADDR-1:0]                          i_dp_segs_addra,
  input  logic                                         i_dp_bit_valid,
  output logic [CFG_ORDER_NUM*CFG_SINGE_ORDER_WID-1:0] o_cfg_bit_info,
  output logic                                         o_cfg_bit_updata,
  output logic                                         o_cfg_busy,
  output logic                                         o_win_timeout,
  output logic [15:0]                                  o_commit_cnt
);

  localparam int BANK_W = CFG_ORDER_NUM * CFG_SINGE_ORDER_WID;
  localparam int CNT_W  = $clog2(WIN_TIMEOUT);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_IDLE = 3'd2,
    APPLY     = 3'd3,
    HOLD      = 3'd4,
    RESTORE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              win_q, win_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic              tmo_q, tmo_d;
  logic              updata_q, updata_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [15:0]       commit_cnt_q, commit_cnt_d;

  logic seg_start;
  logic abort_in_load;
  logic accept;

  assign seg_start     = i_dp_segs_valid && (i_dp_segs_addra == '0);
  assign abort_in_load = (state_q == LOAD) && i_cfg_abort;
  assign accept        = s_cfg_valid && ready_q && !abort_in_load;

  // A new packet start re-opens the window even if its predecessor closes this cycle.
  always_comb begin
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    tmo_d     = 1'b0;
    if (seg_start) begin
      win_d     = 1'b1;
      win_cnt_d = '0;
    end else if (win_q) begin
      if (i_dp_bit_valid) begin
        win_d     = 1'b0;
        win_cnt_d = '0;
      end else if (win_cnt_q == WIN_LAST) begin
        win_d     = 1'b0;
        win_cnt_d = '0;
        tmo_d     = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    commit_cnt_d = commit_cnt_q;
    updata_d     = 1'b0;

    if (accept) begin
      shadow_d[s_cfg_index*CFG_SINGE_ORDER_WID +: CFG_SINGE_ORDER_WID] = s_cfg_instr;
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = s_cfg_last ? WAIT_IDLE : LOAD;
      end
      LOAD: begin
        if (i_cfg_abort)                 state_d = RESTORE;
        else if (accept && s_cfg_last)   state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (i_cfg_abort)                 state_d = RESTORE;
        else if (!win_q && !seg_start)   state_d = APPLY;
      end
      APPLY: begin
        active_d     = shadow_q;
        updata_d     = 1'b1;
        commit_cnt_d = commit_cnt_q + 16'd1;
        state_d      = HOLD;
      end
      HOLD: begin
        state_d = IDLE;
      end
      RESTORE: begin
        shadow_d = active_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
      win_q        <= 1'b0;
      win_cnt_q    <= '0;
      tmo_q        <= 1'b0;
      updata_q     <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      win_q        <= win_d;
      win_cnt_q    <= win_cnt_d;
      tmo_q        <= tmo_d;
      updata_q     <= updata_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign s_cfg_ready      = ready_q;
  assign o_cfg_bit_info   = active_q;
  assign o_cfg_bit_updata = updata_q;
  assign o_cfg_busy       = busy_q;
  assign o_win_timeout    = tmo_q;
  assign o_commit_cnt     = commit_cnt_q;

endmodule
